// File: rtl/rtc_timer_pkg.sv
// Shared timer window constants, register offsets and byte-merge helper
// for the rtc_timer machine-timer peripheral.
package rtc_timer_pkg;

    localparam logic [31:0] timer_base_address = 32'h0020_0000;
    localparam logic [31:0] timer_top_address  = 32'h0020_0010;
    localparam int          clk_divider_rtc    = 15;

    typedef enum logic [1:0] {
        REG_CMP_LO  = 2'd0,
        REG_CMP_HI  = 2'd1,
        REG_TIME_LO = 2'd2,
        REG_TIME_HI = 2'd3
    } reg_sel_e;

    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_v,
        input logic [31:0] new_v,
        input logic [3:0]  strb
    );
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                r[8*i +: 8] = new_v[8*i +: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rtc_timer_rtc_tick.sv
// RTC tick generator: divides the system clock into a square phase and
// emits a one-cycle pulse on each rising phase edge.
module rtc_tick
    import rtc_timer_pkg::*;
#(
    parameter int DIV = clk_divider_rtc
) (
    input  logic clock,
    input  logic reset,
    output logic o_tick
);

    localparam int W = (DIV < 1) ? 1 : $clog2(DIV + 1);
    localparam logic [W-1:0] LAST = W'(DIV);

    logic [W-1:0] r_cnt;
    logic         r_phase;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (r_cnt == LAST) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Pulse in the cycle whose closing edge flips the phase 0 -> 1.
    assign o_tick = (r_cnt == LAST) && !r_phase;

endmodule

// File: rtl/rtc_timer.sv
// Memory-mapped 64-bit mtime/mtimecmp machine timer with a fixed
// one-cycle bus response and a registered level interrupt.
module rtc_timer
    import rtc_timer_pkg::*;
#(
    parameter logic [31:0] BASE = timer_base_address,
    parameter int          DIV  = clk_divider_rtc
) (
    input  logic        reset,
    input  logic        clock,
    input  logic        timer_valid,
    input  logic        timer_instr,
    input  logic [31:0] timer_addr,
    input  logic [31:0] timer_wdata,
    input  logic [3:0]  timer_wstrb,
    output logic [31:0] timer_rdata,
    output logic        timer_ready,
    output logic        timer_irq
);

    localparam logic [31:0] TOP =
        BASE + (timer_top_address - timer_base_address);

    logic [63:0] r_mtime;
    logic [63:0] r_mtimecmp;
    logic        r_irq;
    logic        r_ready;
    logic [31:0] r_rdata;

    logic        w_tick;
    logic        w_hit;
    logic        w_wr;
    logic        w_rd;
    logic [31:0] w_cur;
    logic [31:0] w_merged;
    reg_sel_e    w_sel;
    logic        w_unused;

    rtc_tick #(.DIV(DIV)) u_tick (
        .clock  (clock),
        .reset  (reset),
        .o_tick (w_tick)
    );

    assign w_unused = timer_instr;
    assign w_hit = (timer_addr >= BASE) && (timer_addr < TOP);
    assign w_wr  = timer_valid && w_hit && (|timer_wstrb);
    assign w_rd  = timer_valid && w_hit && !(|timer_wstrb);
    assign w_sel = reg_sel_e'(timer_addr[3:2]);

    always_comb begin
        w_cur = '0;
        unique case (w_sel)
            REG_CMP_LO:  w_cur = r_mtimecmp[31:0];
            REG_CMP_HI:  w_cur = r_mtimecmp[63:32];
            REG_TIME_LO: w_cur = r_mtime[31:0];
            REG_TIME_HI: w_cur = r_mtime[63:32];
            default:     w_cur = '0;
        endcase
    end

    assign w_merged = merge_bytes(w_cur, timer_wdata, timer_wstrb);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_mtime    <= '0;
            r_mtimecmp <= '1;
            r_irq      <= 1'b0;
            r_ready    <= 1'b0;
            r_rdata    <= '0;
        end else begin
            r_ready <= timer_valid;
            r_rdata <= w_rd ? w_cur : '0;
            r_irq   <= (r_mtime >= r_mtimecmp);
            if (w_wr && w_sel == REG_CMP_LO) begin
                r_mtimecmp[31:0] <= w_merged;
            end
            if (w_wr && w_sel == REG_CMP_HI) begin
                r_mtimecmp[63:32] <= w_merged;
            end
            // A software write to mtime swallows a coincident tick.
            if (w_wr && w_sel == REG_TIME_LO) begin
                r_mtime[31:0] <= w_merged;
            end else if (w_wr && w_sel == REG_TIME_HI) begin
                r_mtime[63:32] <= w_merged;
            end else if (w_tick) begin
                r_mtime <= r_mtime + 64'd1;
            end
        end
    end

    assign timer_ready = r_ready && !reset;
    assign timer_rdata = reset ? '0 : r_rdata;
    assign timer_irq   = r_irq;

endmodule

// File: tb/tb_rtc_timer.sv
// Self-checking bench for rtc_timer: constant vectors, corner sequences
// and randomized traffic against a cycle-count based reference model.
module tb_rtc_timer;

    localparam int          DIV  = 1;
    localparam int          PER  = 2 * (DIV + 1);
    localparam logic [31:0] BASE = 32'h0020_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        timer_valid = 1'b0;
    logic        timer_instr = 1'b0;
    logic [31:0] timer_addr = '0;
    logic [31:0] timer_wdata = '0;
    logic [3:0]  timer_wstrb = '0;
    logic [31:0] timer_rdata;
    logic        timer_ready;
    logic        timer_irq;

    int checks = 0;
    int failures = 0;

    logic [63:0] m_time;
    logic [63:0] m_cmp;
    int          m_cyc;
    logic        m_rdy_q;
    logic [31:0] m_rd_q;
    logic        m_irq;
    logic        e_ready;
    logic [31:0] e_rdata;
    logic        e_irq;

    rtc_timer #(.BASE(BASE), .DIV(DIV)) dut (
        .reset       (reset),
        .clock       (clock),
        .timer_valid (timer_valid),
        .timer_instr (timer_instr),
        .timer_addr  (timer_addr),
        .timer_wdata (timer_wdata),
        .timer_wstrb (timer_wstrb),
        .timer_rdata (timer_rdata),
        .timer_ready (timer_ready),
        .timer_irq   (timer_irq)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        v;
        logic [3:0]  off;
        logic [31:0] wd;
        logic [3:0]  ws;
        logic        er;
        logic [31:0] ed;
        logic        ei;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mreg(input logic [31:0] a);
        case (a[3:2])
            2'd0:    return m_cmp[31:0];
            2'd1:    return m_cmp[63:32];
            2'd2:    return m_time[31:0];
            default: return m_time[63:32];
        endcase
    endfunction

    function automatic logic [31:0] mmerge(input logic [31:0] o,
                                           input logic [31:0] n,
                                           input logic [3:0] s);
        logic [31:0] mask;
        mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (o & ~mask) | (n & mask);
    endfunction

    // Drive this cycle's inputs and note what the outputs should be now.
    task automatic drive(input logic v, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] ws,
                         input logic rst);
        timer_valid = v;
        timer_addr  = a;
        timer_wdata = wd;
        timer_wstrb = ws;
        timer_instr = 1'($urandom_range(0, 1));
        reset       = rst;
        e_ready = m_rdy_q && !rst;
        e_rdata = (m_rdy_q && !rst) ? m_rd_q : 32'h0;
        e_irq   = m_irq;
        #1;
    endtask

    // Apply the edge to the model, then move to just after the edge.
    task automatic advance();
        bit tk;
        logic nirq;
        if (reset) begin
            m_time  = '0;
            m_cmp   = '1;
            m_cyc   = 0;
            m_rdy_q = 1'b0;
            m_rd_q  = '0;
            m_irq   = 1'b0;
        end else begin
            tk   = (m_cyc % PER) == DIV;
            nirq = (m_time >= m_cmp);
            m_rdy_q = timer_valid;
            m_rd_q  = (timer_valid && timer_wstrb == 0) ?
                      mreg(timer_addr) : 32'h0;
            if (timer_valid && timer_wstrb != 0) begin
                case (timer_addr[3:2])
                    2'd0: m_cmp[31:0] =
                        mmerge(m_cmp[31:0], timer_wdata, timer_wstrb);
                    2'd1: m_cmp[63:32] =
                        mmerge(m_cmp[63:32], timer_wdata, timer_wstrb);
                    2'd2: begin
                        m_time[31:0] =
                            mmerge(m_time[31:0], timer_wdata, timer_wstrb);
                        tk = 0;
                    end
                    default: begin
                        m_time[63:32] =
                            mmerge(m_time[63:32], timer_wdata, timer_wstrb);
                        tk = 0;
                    end
                endcase
            end
            if (tk) m_time = m_time + 64'd1;
            m_irq = nirq;
            m_cyc++;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic step(input logic v, input logic [3:0] off,
                        input logic [31:0] wd, input logic [3:0] ws);
        drive(v, BASE + {28'h0, off}, wd, ws, 1'b0);
        advance();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'h0, 32'h0, 4'h0);
    endtask

    task automatic do_reset();
        drive(1'b0, BASE, 32'h0, 4'h0, 1'b1);
        advance();
        drive(1'b0, BASE, 32'h0, 4'h0, 1'b1);
        advance();
    endtask

    vec_t tbl[12];

    initial begin
        tbl = '{
            '{1'b1, 4'h0, 32'h0,        4'h0, 1'b0, 32'h0,        1'b0},
            '{1'b1, 4'h4, 32'h0,        4'h0, 1'b1, 32'hFFFFFFFF, 1'b0},
            '{1'b1, 4'h8, 32'h0,        4'h0, 1'b1, 32'hFFFFFFFF, 1'b0},
            '{1'b1, 4'hC, 32'h0,        4'h0, 1'b1, 32'h1,        1'b0},
            '{1'b0, 4'h0, 32'h0,        4'h0, 1'b1, 32'h0,        1'b0},
            '{1'b1, 4'h0, 32'h12345678, 4'hF, 1'b0, 32'h0,        1'b0},
            '{1'b1, 4'h0, 32'h0,        4'h0, 1'b1, 32'h0,        1'b0},
            '{1'b1, 4'h4, 32'h000000AB, 4'h1, 1'b1, 32'h12345678, 1'b0},
            '{1'b1, 4'h6, 32'h0,        4'h0, 1'b1, 32'h0,        1'b0},
            '{1'b0, 4'h0, 32'h0,        4'h0, 1'b1, 32'hFFFFFFAB, 1'b0},
            '{1'b1, 4'h8, 32'h0,        4'h0, 1'b0, 32'h0,        1'b0},
            '{1'b0, 4'h0, 32'h0,        4'h0, 1'b1, 32'h3,        1'b0}
        };

        @(posedge clock);
        #1;

        // Register map right after reset.
        do_reset();
        foreach (tbl[i]) begin
            drive(tbl[i].v, BASE + {28'h0, tbl[i].off},
                  tbl[i].wd, tbl[i].ws, 1'b0);
            chk($sformatf("vec%0d_ready", i), 32'(timer_ready),
                32'(tbl[i].er));
            chk($sformatf("vec%0d_rdata", i), timer_rdata, tbl[i].ed);
            chk($sformatf("vec%0d_irq", i), 32'(timer_irq),
                32'(tbl[i].ei));
            advance();
        end

        // Free run: one tick per 2*(DIV+1) clocks.
        do_reset();
        idle(40);
        step(1'b1, 4'h8, 32'h0, 4'h0);
        drive(1'b0, BASE, 32'h0, 4'h0, 1'b0);
        chk("freerun_ready", 32'(timer_ready), 32'h1);
        chk("freerun_mtime", timer_rdata, 32'd10);
        advance();

        // Low-to-high carry.
        do_reset();
        step(1'b1, 4'hC, 32'h0, 4'hF);
        idle(1);
        step(1'b1, 4'h8, 32'hFFFFFFFF, 4'hF);
        idle(3);
        step(1'b1, 4'hC, 32'h0, 4'h0);
        drive(1'b1, BASE + 32'h8, 32'h0, 4'h0, 1'b0);
        chk("carry_hi", timer_rdata, 32'h1);
        advance();
        drive(1'b0, BASE, 32'h0, 4'h0, 1'b0);
        chk("carry_lo", timer_rdata, 32'h0);
        advance();

        // Interrupt rise at mtime == mtimecmp, fall after raising cmp.
        do_reset();
        step(1'b1, 4'h4, 32'h0, 4'hF);
        step(1'b1, 4'h0, 32'h5, 4'hF);
        idle(16);
        drive(1'b0, BASE, 32'h0, 4'h0, 1'b0);
        chk("irq_before", 32'(timer_irq), 32'h0);
        advance();
        drive(1'b0, BASE, 32'h0, 4'h0, 1'b0);
        chk("irq_rise", 32'(timer_irq), 32'h1);
        advance();
        drive(1'b1, BASE, 32'hFFFFFFFF, 4'hF, 1'b0);
        chk("irq_hold", 32'(timer_irq), 32'h1);
        advance();
        drive(1'b0, BASE, 32'h0, 4'h0, 1'b0);
        chk("irq_lag", 32'(timer_irq), 32'h1);
        advance();
        drive(1'b0, BASE, 32'h0, 4'h0, 1'b0);
        chk("irq_fall", 32'(timer_irq), 32'h0);
        advance();

        // Partial mtime write colliding with a tick.
        do_reset();
        step(1'b1, 4'h8, 32'hAABBCCDD, 4'hF);
        idle(4);
        step(1'b1, 4'h8, 32'h00000100, 4'h3);
        step(1'b1, 4'h8, 32'h0, 4'h0);
        drive(1'b0, BASE, 32'h0, 4'h0, 1'b0);
        chk("collide_lo", timer_rdata, 32'hAABB0100);
        advance();
        idle(2);
        step(1'b1, 4'h8, 32'h0, 4'h0);
        drive(1'b0, BASE, 32'h0, 4'h0, 1'b0);
        chk("collide_next", timer_rdata, 32'hAABB0101);
        advance();

        // Reset during a read's response cycle.
        do_reset();
        step(1'b1, 4'h8, 32'h7, 4'hF);
        drive(1'b1, BASE + 32'h8, 32'h0, 4'h0, 1'b0);
        chk("b2b_wr_ready", 32'(timer_ready), 32'h1);
        chk("b2b_wr_rdata", timer_rdata, 32'h0);
        advance();
        drive(1'b0, BASE, 32'h0, 4'h0, 1'b1);
        chk("rst_ready", 32'(timer_ready), 32'h0);
        chk("rst_rdata", timer_rdata, 32'h0);
        advance();
        step(1'b1, 4'h8, 32'h0, 4'h0);
        drive(1'b1, BASE, 32'h0, 4'h0, 1'b0);
        chk("rst_mtime", timer_rdata, 32'h0);
        advance();
        drive(1'b1, BASE + 32'h4, 32'h0, 4'h0, 1'b0);
        chk("rst_cmp_lo", timer_rdata, 32'hFFFFFFFF);
        advance();
        drive(1'b0, BASE, 32'h0, 4'h0, 1'b0);
        chk("rst_cmp_hi", timer_rdata, 32'hFFFFFFFF);
        chk("rst_irq", 32'(timer_irq), 32'h0);
        advance();

        // Randomized traffic against the reference model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            logic        rv;
            logic        rr;
            logic [1:0]  ro;
            logic [3:0]  rs;
            logic [31:0] rd;
            int          pick;
            rr = ($urandom_range(0, 299) == 0);
            rv = 1'($urandom_range(0, 1));
            ro = 2'($urandom_range(0, 3));
            rs = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(0, 15));
            pick = $urandom_range(0, 3);
            if (pick == 0) rd = $urandom;
            else if (ro[0]) rd = $urandom_range(0, 2);
            else rd = $urandom_range(0, 300);
            drive(rv, BASE + {28'h0, ro, 2'($urandom_range(0, 3))},
                  rd, rs, rr);
            chk("rnd_ready", 32'(timer_ready), 32'(e_ready));
            chk("rnd_rdata", timer_rdata, e_rdata);
            chk("rnd_irq", 32'(timer_irq), 32'(e_irq));
            advance();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
